// File: rtl/br_pred_pkg.sv
// Shared definitions for the branch predictor: counter encodings, default sizes
// and the saturating-counter update rule.
package br_pred_pkg;

   typedef enum logic [1:0] {
      CNT_SNT = 2'd0,
      CNT_WNT = 2'd1,
      CNT_WT  = 2'd2,
      CNT_ST  = 2'd3
   } cnt_e;

   localparam int DEF_IDX_W   = 6;
   localparam int DEF_Q_DEPTH = 4;

   function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      nxt = cnt;
      if (taken && (cnt != CNT_ST)) begin
         nxt = cnt + 2'd1;
      end else if (!taken && (cnt != CNT_SNT)) begin
         nxt = cnt - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/br_pred_fifo.sv
// In-flight prediction queue: a small FIFO with an extra pointer bit to tell
// full from empty, and a flush that overrides any same-cycle push or pop.
module br_pred_fifo
   import br_pred_pkg::*;
#(
   parameter int DW    = DEF_IDX_W + 1,
   parameter int DEPTH = DEF_Q_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int PW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [PW:0]   wr_ptr_q, wr_ptr_d;
   logic [PW:0]   rd_ptr_q, rd_ptr_d;
   logic          do_push;
   logic          do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign dout    = mem_q[rd_ptr_q[PW-1:0]];

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            mem_d[wr_ptr_q[PW-1:0]] = din;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/br_pred.sv
// Bimodal branch predictor: a flop-based table of 2-bit counters looked up
// combinationally, trained in order from a queue of outstanding predictions.
module br_pred
   import br_pred_pkg::*;
#(
   parameter int IDX_W   = DEF_IDX_W,
   parameter int Q_DEPTH = DEF_Q_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lk_valid,
   input  logic [31:0] lk_pc,
   output logic        lk_ready,
   output logic        lk_taken,
   input  logic        res_valid,
   input  logic        res_taken,
   output logic        mispredict,
   output logic        err
);

   localparam int ENTRIES = 1 << IDX_W;

   logic [1:0]     pht_q [ENTRIES];
   logic [1:0]     pht_d [ENTRIES];
   logic           mispredict_q, mispredict_d;
   logic           err_q, err_d;

   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W:0]   q_din;
   logic [IDX_W:0]   q_dout;
   logic [IDX_W-1:0] pop_idx;
   logic             pop_pred;
   logic             q_full;
   logic             q_empty;
   logic             push_en;
   logic             pop_en;
   logic             unused_pc;

   assign lk_idx    = lk_pc[IDX_W+1:2];
   assign unused_pc = ^{lk_pc[31:IDX_W+2], lk_pc[1:0]};
   assign lk_taken  = pht_q[lk_idx][1];
   assign lk_ready  = !q_full;
   assign push_en   = lk_valid && lk_ready;
   assign pop_en    = res_valid && !q_empty;
   assign q_din     = {lk_idx, lk_taken};
   assign pop_idx   = q_dout[IDX_W:1];
   assign pop_pred  = q_dout[0];

   br_pred_fifo #(
      .DW    (IDX_W + 1),
      .DEPTH (Q_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_en),
      .pop   (pop_en),
      .flush (mispredict_d),
      .din   (q_din),
      .dout  (q_dout),
      .full  (q_full),
      .empty (q_empty)
   );

   always_comb begin
      pht_d        = pht_q;
      mispredict_d = pop_en && (pop_pred != res_taken);
      err_d        = err_q || (res_valid && q_empty);
      if (pop_en) begin
         pht_d[pop_idx] = cnt_update(pht_q[pop_idx], res_taken);
      end
   end

   // Parallel reset of the whole table, so lookups are valid the cycle after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            pht_q[i] <= CNT_WNT;
         end
         mispredict_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         pht_q        <= pht_d;
         mispredict_q <= mispredict_d;
         err_q        <= err_d;
      end
   end

   assign mispredict = mispredict_q;
   assign err        = err_q;

endmodule

// File: doc/br_pred.md
BR_PRED -- requirements
Module: br_pred

Interface
REQ-001 The module SHALL have parameter IDX_W, default 6, meaning log2 of the pattern-history-table entry count (64 entries).
REQ-002 The module SHALL have parameter Q_DEPTH, default 4, meaning the maximum number of in-flight predictions (power of two).
REQ-003 The module SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-005 The module SHALL have port lk_valid  input  1  meaning fetch presents a conditional branch for prediction.
REQ-006 The module SHALL have port lk_pc  input  32  meaning the branch PC, with index = lk_pc[IDX_W+1:2].
REQ-007 The module SHALL have port lk_ready  output  1  meaning the predictor can accept a lookup this cycle.
REQ-008 The module SHALL have port lk_taken  output  1  meaning the predicted direction for lk_pc, combinational.
REQ-009 The module SHALL have port res_valid  input  1  meaning the branch-resolution unit reports the oldest in-flight branch.
REQ-010 The module SHALL have port res_taken  input  1  meaning the resolved direction (the resolution unit's exe signal).
REQ-011 The module SHALL have port mispredict  output  1  meaning a registered one-cycle pulse requesting a fetch flush.
REQ-012 The module SHALL have port err  output  1  meaning a sticky flag set on resolution with no in-flight prediction.

Function
REQ-013 The pattern-history table SHALL hold 2^IDX_W 2-bit saturating counters, where a value of 2 or 3 predicts taken.
REQ-014 lk_taken SHALL equal bit[1] of the counter at the lk_pc index in the same cycle, reflecting table contents before any same-cycle write.
REQ-015 lk_ready SHALL be 1 exactly when the in-flight queue holds fewer than Q_DEPTH entries, independent of a same-cycle resolution.
REQ-016 A lookup SHALL be accepted when lk_valid and lk_ready are both 1, pushing {index, lk_taken} into the FIFO queue.
REQ-017 A resolution SHALL pop the oldest queue entry when res_valid is 1 and the queue is non-empty.
REQ-018 On a pop, the counter at the popped index SHALL increment when res_taken is 1 and decrement when res_taken is 0, saturating at 3 and 0, with the write visible on the next cycle.
REQ-019 mispredict SHALL be 1 in the cycle after a pop whose stored prediction differs from res_taken, and 0 otherwise.
REQ-020 A mispredicting pop SHALL empty the queue and discard any same-cycle accepted lookup, because flush wins.
REQ-021 A correct pop and an accepted push in the same cycle SHALL leave the occupancy unchanged.
REQ-022 When res_valid is 1 with an empty queue, the module SHALL leave the table and queue unchanged, set err, and keep mispredict at 0.
REQ-023 Queue pointers SHALL wrap modulo Q_DEPTH, with full and empty distinguished by an extra pointer bit or an occupancy counter.

Reset
REQ-024 While rst is 1, all counters SHALL be set to 1 (weakly not-taken).
REQ-025 While rst is 1, the queue SHALL be emptied, and mispredict and err SHALL be 0.
REQ-026 While rst is 1, lookups and resolutions SHALL be ignored, and a reset asserted mid-operation SHALL discard all in-flight entries.
REQ-027 Initialising the 64-entry table MAY take one cycle using a parallel clear, so that lk_ready is 1 in the first cycle after rst deasserts.

Structure
REQ-028 The counter encodings (SNT=0, WNT=1, WT=2, ST=3), the default IDX_W, and the default Q_DEPTH SHALL reside in the shared core package.
REQ-029 The in-flight queue SHALL be a separate sub-module, br_pred_fifo, with push, pop, flush, full and empty signals and a data width of IDX_W+1.
REQ-030 The table SHALL be built from flops rather than inferred synchronous RAM, because lookup is combinational.

Verification
REQ-031 Scenario: after reset, a lookup at pc 0x00400010 -> lk_taken=0; resolve taken -> mispredict=1 the next cycle; the counter at index 4 becomes 2; a repeated lookup -> lk_taken=1.
REQ-032 Scenario: four lookups with no resolution -> lk_ready=0 on the fifth cycle; a fifth lk_valid is not accepted; one correct resolution -> lk_ready=1 the next cycle.
REQ-033 Scenario: with three entries in flight, a mispredicting resolution together with an accepted lookup -> queue empty the next cycle and mispredict=1 for exactly one cycle.
REQ-034 Scenario: five taken resolutions at one index -> counter saturates at 3; one not-taken resolution -> counter 2, and lk_taken stays 1.
REQ-035 Scenario: res_valid with an empty queue -> err=1 and stays 1, with the table unchanged; rst -> err=0.
REQ-036 Scenario: rst asserted while two entries are in flight -> the next cycle shows an empty queue, all counters at 1, and no mispredict pulse.
